// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared widths, NOP encoding and fetch FSM state encodings
package instruction_fetch_pkg;

  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_INSTR_W = 14;
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_WORD = 14'h0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: pc to program memory, IR capture, wait states, backpressure, flush
// Optional halt handshake (halt_req/halted, S_HALT) is built only when IFETCH_HALT_EN is defined.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_incr_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  input  logic               ir_take,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid
`ifdef IFETCH_HALT_EN
  ,
  input  logic               halt_req,
  output logic               halted
`endif
);

  fetch_state_e       state_q, state_d;
  logic               ir_valid_q, ir_valid_d;
  logic [INSTR_W-1:0] ir_out_q, ir_out_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;

  logic req;
  logic flush_live;
  logic accept;

  // Request is decided purely by state and IR occupancy; once in S_WAIT it is held until accept or flush.
  always_comb begin
    req = 1'b0;
    case (state_q)
      S_FETCH: begin
`ifdef IFETCH_HALT_EN
        req = (~ir_valid_q | ir_take) & ~halt_req;
`else
        req = ~ir_valid_q | ir_take;
`endif
      end
      S_WAIT:  req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  // Flush is meaningless before the first fetch after reset.
  assign flush_live = flush & (state_q != S_IDLE);
  assign accept     = req & imem_ready & ~flush;

  always_comb begin
    state_d = state_q;
    if (flush_live) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE: begin
`ifdef IFETCH_HALT_EN
          state_d = halt_req ? S_HALT : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end
        S_FETCH: begin
`ifdef IFETCH_HALT_EN
          if (halt_req) begin
            if (!ir_valid_q) state_d = S_HALT;
          end else if (req && !imem_ready) begin
            state_d = S_WAIT;
          end
`else
          if (req && !imem_ready) state_d = S_WAIT;
`endif
        end
        S_WAIT: begin
          if (accept) state_d = S_FETCH;
        end
        S_FLUSH: begin
`ifdef IFETCH_HALT_EN
          state_d = halt_req ? S_HALT : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end
`ifdef IFETCH_HALT_EN
        S_HALT: begin
          if (!halt_req) state_d = S_FETCH;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  // IR always reads NOP_WORD while empty, so decode never sees a stale word.
  always_comb begin
    ir_valid_d = ir_valid_q;
    ir_out_d   = ir_out_q;
    ir_pc_d    = ir_pc_q;
    if (flush_live) begin
      ir_valid_d = 1'b0;
      ir_out_d   = NOP_WORD;
    end else if (accept) begin
      ir_valid_d = 1'b1;
      ir_out_d   = imem_rdata;
      ir_pc_d    = pc_in;
    end else if (ir_take) begin
      ir_valid_d = 1'b0;
      ir_out_d   = NOP_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_valid_q <= 1'b0;
      ir_out_q   <= NOP_WORD;
      ir_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      ir_valid_q <= ir_valid_d;
      ir_out_q   <= ir_out_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  assign pc_incr_en = accept;
  assign imem_req   = req;
  assign imem_addr  = pc_in;
  assign ir_out     = ir_out_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;

`ifdef IFETCH_HALT_EN
  assign halted = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized checks of instruction_fetch against a request/IR occupancy model
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] pc_in;
  logic        pc_incr_en;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic        imem_ready;
  logic [13:0] imem_rdata;
  logic        flush;
  logic        ir_take;
  logic [13:0] ir_out;
  logic [12:0] ir_pc;
  logic        ir_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side program counter and memory
  logic [12:0] pc;
  logic [13:0] salt;

  // Reference model: cycles since reset, one-cycle flush bubble, outstanding unanswered request, IR contents
  logic        m_started;
  logic        m_bubble;
  logic        m_pending;
  logic        m_valid;
  logic [13:0] m_ir;
  logic [12:0] m_irpc;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .pc_incr_en (pc_incr_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .ir_take    (ir_take),
    .ir_out     (ir_out),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] mem_word(input logic [12:0] a);
    return ({1'b0, a} + 14'h100) ^ salt;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    ir_take    = 1'b0;
    flush      = 1'b0;
    pc         = 13'd0;
    pc_in      = 13'd0;
    imem_rdata = mem_word(13'd0);
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_imem_req", 32'(imem_req), 32'd0);
    check_value("rst_pc_incr_en", 32'(pc_incr_en), 32'd0);
    check_value("rst_ir_valid", 32'(ir_valid), 32'd0);
    check_value("rst_ir_out", 32'(ir_out), 32'h0000);
    check_value("rst_ir_pc", 32'(ir_pc), 32'd0);
    rst_n     = 1'b1;
    m_started = 1'b0;
    m_bubble  = 1'b0;
    m_pending = 1'b0;
    m_valid   = 1'b0;
    m_ir      = 14'h0000;
    m_irpc    = 13'd0;
  endtask

  // One clock: drive at negedge, compare against the model, advance model and pc, return just after posedge.
  task automatic cycle(input logic rdy, input logic tk, input logic fl, input logic [12:0] tgt);
    logic        e_req;
    logic        e_acc;
    logic        fl_live;
    logic [13:0] rdata;
    @(negedge clk);
    rdata      = mem_word(pc);
    pc_in      = pc;
    imem_rdata = rdata;
    imem_ready = rdy;
    ir_take    = tk;
    flush      = fl;
    #1;
    fl_live = fl && m_started;
    e_req   = m_started && !m_bubble && (m_pending || !m_valid || tk);
    e_acc   = e_req && rdy && !fl;
    check_value("imem_req", 32'(imem_req), 32'(e_req));
    check_value("pc_incr_en", 32'(pc_incr_en), 32'(e_acc));
    check_value("imem_addr", 32'(imem_addr), 32'(pc));
    check_value("ir_valid", 32'(ir_valid), 32'(m_valid));
    check_value("ir_out", 32'(ir_out), m_valid ? 32'(m_ir) : 32'h0000);
    check_value("ir_pc", 32'(ir_pc), 32'(m_irpc));
    if (fl_live) begin
      m_valid   = 1'b0;
      m_bubble  = 1'b1;
      m_pending = 1'b0;
      pc        = tgt;
    end else begin
      m_bubble  = 1'b0;
      m_pending = e_req && !rdy;
      if (e_acc) begin
        m_valid = 1'b1;
        m_ir    = rdata;
        m_irpc  = pc;
        pc      = pc + 13'd1;
      end else if (tk) begin
        m_valid = 1'b0;
      end
    end
    m_started = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
    $fatal(1);
  end

  initial begin
    salt = 14'h0000;
    do_reset();

    // Idle cycle after release: no request yet
    cycle(1'b1, 1'b1, 1'b0, 13'd0);
    check_value("first_req_after_idle", 32'(imem_req), 32'd1);

    // Streaming one instruction per cycle
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 13'd0);
      check_value("stream_ir_pc", 32'(ir_pc), 32'(k));
      check_value("stream_ir_out", 32'(ir_out), 32'(14'h100 + k));
    end
    cycle(1'b1, 1'b1, 1'b0, 13'd0);

    // Three wait states at pc=5, then accept
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 13'd0);
      check_value("wait_addr", 32'(imem_addr), 32'd5);
      check_value("wait_req_held", 32'(imem_req), 32'd1);
    end
    cycle(1'b1, 1'b1, 1'b0, 13'd0);
    check_value("wait_ir_pc", 32'(ir_pc), 32'd5);
    check_value("wait_ir_out", 32'(ir_out), 32'h105);

    // Flush at pc=7 with ready high, target 4
    cycle(1'b1, 1'b1, 1'b0, 13'd0);
    cycle(1'b1, 1'b1, 1'b1, 13'd4);
    check_value("flush_ir_valid", 32'(ir_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 13'd0);
    check_value("bubble_ir_valid", 32'(ir_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 13'd0);
    check_value("target_ir_pc", 32'(ir_pc), 32'd4);
    check_value("target_ir_out", 32'(ir_out), 32'h104);

    // Stream to pc=9, then hold IR for four cycles
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 13'd0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 13'd0);
      check_value("bp_ir_pc", 32'(ir_pc), 32'd9);
      check_value("bp_ir_out", 32'(ir_out), 32'h109);
      check_value("bp_req", 32'(imem_req), 32'd0);
    end
    check_value("bp_pc_held", 32'(imem_addr), 32'd10);
    cycle(1'b1, 1'b1, 1'b0, 13'd0);
    check_value("bp_resume_ir_pc", 32'(ir_pc), 32'd10);

    // Randomized traffic, including jumps near the pc wrap and one mid-run reset
    salt = 14'($urandom);
    for (int i = 0; i < 1500; i++) begin
      logic        rdy;
      logic        tk;
      logic        fl;
      logic [12:0] tgt;
      if (i == 700) begin
        do_reset();
        salt = 14'($urandom);
      end
      rdy = ($urandom_range(0, 3) != 0);
      tk  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 13'h1FFD : 13'($urandom);
      cycle(rdy, tk, fl, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
